// File: rtl/timer_ctl_master.sv
// timer_ctl_master: sequences interval-timer bus accesses for start/stop, timeout ack and counter snapshots.
// Bus outputs are registered from the next state, so a command sampled in cycle T drives the bus in T+1.
module timer_ctl_master #(
    parameter int TICK_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           cfg_period_i,
    input  logic                  cfg_continuous_i,
    input  logic                  cmd_start_i,
    input  logic                  cmd_stop_i,
    input  logic                  cmd_snap_i,
    output logic                  busy_o,
    output logic                  running_o,
    output logic                  tick_o,
    output logic [TICK_CNT_W-1:0] tick_count_o,
    output logic [31:0]           snap_data_o,
    output logic                  snap_valid_o,
    output logic [2:0]            m_address_o,
    output logic                  m_chipselect_o,
    output logic                  m_write_n_o,
    output logic [15:0]           m_writedata_o,
    input  logic [15:0]           m_readdata_i,
    input  logic                  m_irq_i
);
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, ACK_WAIT, WR_STOP,
        SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE
    } state_e;
    state_e                state_q, state_d;
    logic [31:0]           period_q, period_d;
    logic                  cont_q, cont_d;
    logic                  tick_q, tick_d;
    logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
    logic                  running_q, running_d;
    logic [15:0]           snap_lo_q, snap_lo_d;
    logic [31:0]           snap_data_q, snap_data_d;
    logic                  snap_valid_q, snap_valid_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  snap_pend_q, snap_pend_d;
    logic [2:0]            addr_q, addr_d;
    logic                  cs_q, cs_d;
    logic                  wn_q, wn_d;
    logic [15:0]           wd_q, wd_d;
    logic                  start_go, stop_req, snap_req;
    assign busy_o   = !(state_q == IDLE || state_q == RUN);
    assign stop_req = cmd_stop_i || stop_pend_q;
    assign snap_req = cmd_snap_i || snap_pend_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = cmd_start_i ? WR_PL : snap_req ? SNAP_W : IDLE;
            WR_PL:     state_d = WR_PH;
            WR_PH:     state_d = WR_CTL;
            WR_CTL:    state_d = RUN;
            RUN:       state_d = stop_req ? WR_STOP : cmd_start_i ? WR_PL : m_irq_i ? ACK : snap_req ? SNAP_W : RUN;
            ACK:       state_d = ACK_WAIT;
            ACK_WAIT:  state_d = cont_q ? RUN : IDLE;
            WR_STOP:   state_d = IDLE;
            SNAP_W:    state_d = SNAP_RL;
            SNAP_RL:   state_d = SNAP_RH;
            SNAP_RH:   state_d = SNAP_DONE;
            SNAP_DONE: state_d = running_q ? RUN : IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        start_go     = state_d == WR_PL;
        period_d     = start_go ? cfg_period_i : period_q;
        cont_d       = start_go ? cfg_continuous_i : cont_q;
        tick_d       = state_d == ACK;
        tick_count_d = start_go ? '0 : tick_d ? tick_count_q + TICK_CNT_W'(1) : tick_count_q;
        running_d    = state_q == WR_CTL ? 1'b1 : state_d == IDLE ? 1'b0 : running_q;
        snap_lo_d    = state_q == SNAP_RH ? m_readdata_i : snap_lo_q;
        snap_valid_d = state_q == SNAP_DONE;
        snap_data_d  = snap_valid_d ? {m_readdata_i, snap_lo_q} : snap_data_q;
        // A stop is moot once idle; a snapshot stays owed until it actually runs.
        stop_pend_d  = (state_d == IDLE || state_d == WR_STOP) ? 1'b0 : (busy_o && cmd_stop_i) ? 1'b1 : stop_pend_q;
        snap_pend_d  = state_d == SNAP_W ? 1'b0 : cmd_snap_i ? 1'b1 : snap_pend_q;
        addr_d       = 3'd0;
        cs_d         = 1'b1;
        wn_d         = 1'b0;
        wd_d         = 16'h0000;
        case (state_d)
            WR_PL:   begin addr_d = 3'd2; wd_d = period_d[15:0]; end
            WR_PH:   begin addr_d = 3'd3; wd_d = period_d[31:16]; end
            WR_CTL:  begin addr_d = 3'd1; wd_d = {12'h000, 1'b0, 1'b1, cont_d, 1'b1}; end
            WR_STOP: begin addr_d = 3'd1; wd_d = 16'h0008; end
            ACK:     addr_d = 3'd0;
            SNAP_W:  addr_d = 3'd4;
            SNAP_RL: begin addr_d = 3'd4; wn_d = 1'b1; end
            SNAP_RH: begin addr_d = 3'd5; wn_d = 1'b1; end
            default: begin cs_d = 1'b0; wn_d = 1'b1; end
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q     <= '0;
            cont_q       <= 1'b0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            running_q    <= 1'b0;
            snap_lo_q    <= '0;
            snap_data_q  <= '0;
            snap_valid_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            addr_q       <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wd_q         <= '0;
        end else begin
            period_q     <= period_d;
            cont_q       <= cont_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            running_q    <= running_d;
            snap_lo_q    <= snap_lo_d;
            snap_data_q  <= snap_data_d;
            snap_valid_q <= snap_valid_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wd_q         <= wd_d;
        end
    end
    assign running_o      = running_q;
    assign tick_o         = tick_q;
    assign tick_count_o   = tick_count_q;
    assign snap_data_o    = snap_data_q;
    assign snap_valid_o   = snap_valid_q;
    assign m_address_o    = addr_q;
    assign m_chipselect_o = cs_q;
    assign m_write_n_o    = wn_q;
    assign m_writedata_o  = wd_q;
endmodule

// File: tb/tb_timer_ctl_master.sv
// tb_timer_ctl_master: directed vector table plus hand-written multi-cycle sequences against a behavioural timer slave.
module tb_timer_ctl_master;
    localparam int TW = 2;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   cfg_period = '0;
    logic          cfg_cont = 1'b0;
    logic          cmd_start = 1'b0, cmd_stop = 1'b0, cmd_snap = 1'b0;
    logic          busy, running, tick, snap_valid;
    logic [TW-1:0] tick_count;
    logic [31:0]   snap_data;
    logic [2:0]    m_addr;
    logic          m_cs, m_wn;
    logic [15:0]   m_wd, m_rd;
    logic          m_irq;
    int            checks = 0, errors = 0, cyc = 0;

    timer_ctl_master #(.TICK_CNT_W(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_period_i(cfg_period), .cfg_continuous_i(cfg_cont),
        .cmd_start_i(cmd_start), .cmd_stop_i(cmd_stop), .cmd_snap_i(cmd_snap),
        .busy_o(busy), .running_o(running), .tick_o(tick), .tick_count_o(tick_count),
        .snap_data_o(snap_data), .snap_valid_o(snap_valid),
        .m_address_o(m_addr), .m_chipselect_o(m_cs), .m_write_n_o(m_wn),
        .m_writedata_o(m_wd), .m_readdata_i(m_rd), .m_irq_i(m_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval-timer slave: counts period..0, flags timeout on reaching 0, reloads.
    logic [31:0] t_period, t_cnt, t_snap;
    logic        t_run, t_cont, t_ito, t_to;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_period <= '0; t_cnt <= '0; t_snap <= '0;
            t_run <= 1'b0; t_cont <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0; m_rd <= '0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to <= 1'b1;
                    t_cnt <= t_period;
                    if (!t_cont) t_run <= 1'b0;
                end else t_cnt <= t_cnt - 1;
            end
            if (m_cs && !m_wn) begin
                case (m_addr)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito <= m_wd[0];
                        t_cont <= m_wd[1];
                        if (m_wd[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
                        if (m_wd[3]) t_run <= 1'b0;
                    end
                    3'd2: t_period[15:0] <= m_wd;
                    3'd3: t_period[31:16] <= m_wd;
                    3'd4, 3'd5: t_snap <= t_cnt;
                    default: ;
                endcase
            end
            m_rd <= !(m_cs && m_wn) ? 16'h0000 : m_addr == 3'd4 ? t_snap[15:0] :
                    m_addr == 3'd5 ? t_snap[31:16] : m_addr == 3'd0 ? {14'h0, t_run, t_to} : 16'h0000;
        end
    end
    assign m_irq = t_to && t_ito;

    typedef struct {
        logic        start, stop, snap;
        logic [2:0]  addr;
        logic        cs, wn;
        logic [15:0] wd;
        logic        busy, run, sv;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t v(logic st, logic sp, logic sn, logic [2:0] a, logic c, logic w,
                               logic [15:0] d, logic b, logic r, logic s);
        vec_t x;
        x.start = st; x.stop = sp; x.snap = sn; x.addr = a; x.cs = c; x.wn = w;
        x.wd = d; x.busy = b; x.run = r; x.sv = s;
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic st, input logic sp, input logic sn);
        cmd_start = st; cmd_stop = sp; cmd_snap = sn;
        step();
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
    endtask

    function automatic logic is_wr(input logic [2:0] a);
        return m_cs && !m_wn && m_addr == a;
    endfunction

    initial begin
        int c_ctl, last, nt, acks, w, vc, tc;
        logic [15:0] ctl_wd;
        // Reset state and quiet bus
        repeat (3) step();
        chk("reset_bus", {11'h0, m_addr, m_cs, m_wn, m_wd}, {11'h0, 3'd0, 1'b0, 1'b1, 16'h0});
        chk("reset_status", {27'h0, busy, running, tick, snap_valid, 1'b0}, 32'h0);
        chk("reset_data", snap_data | 32'(tick_count), 32'h0);
        reset_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (m_cs) acks++;
        end
        chk("idle_no_bus", acks, 0);

        // Vector table: period 0x0001_0003 continuous, long enough that no timeout occurs
        cfg_period = 32'h0001_0003; cfg_cont = 1'b1;
        vq.push_back(v(1,0,0, 3'd2,1,0,16'h0003, 1,0,0));
        vq.push_back(v(0,0,0, 3'd3,1,0,16'h0001, 1,0,0));
        vq.push_back(v(0,0,0, 3'd1,1,0,16'h0007, 1,0,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 0,1,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 0,1,0));
        vq.push_back(v(1,1,0, 3'd1,1,0,16'h0008, 1,1,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 0,0,0));
        vq.push_back(v(0,0,1, 3'd4,1,0,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd4,1,1,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd5,1,1,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 0,0,1));
        vq.push_back(v(1,0,0, 3'd2,1,0,16'h0003, 1,0,0));
        vq.push_back(v(0,0,0, 3'd3,1,0,16'h0001, 1,0,0));
        vq.push_back(v(1,1,1, 3'd1,1,0,16'h0007, 1,0,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 0,1,0));
        vq.push_back(v(0,0,0, 3'd1,1,0,16'h0008, 1,1,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 0,0,0));
        vq.push_back(v(0,0,0, 3'd4,1,0,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd4,1,1,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd5,1,1,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 1,0,0));
        vq.push_back(v(0,0,0, 3'd0,0,1,16'h0000, 0,0,1));
        foreach (vq[i]) begin
            pulse(vq[i].start, vq[i].stop, vq[i].snap);
            chk($sformatf("vec%0d_bus", i), {11'h0, m_addr, m_cs, m_wn, m_wd},
                {11'h0, vq[i].addr, vq[i].cs, vq[i].wn, vq[i].wd});
            chk($sformatf("vec%0d_status", i), {29'h0, busy, running, snap_valid},
                {29'h0, vq[i].busy, vq[i].run, vq[i].sv});
        end
        chk("table_tick_count", 32'(tick_count), 0);

        // Continuous period 20: ticks every 21 cycles, 2-bit count wraps 3 -> 0
        cfg_period = 32'd20; cfg_cont = 1'b1;
        pulse(1, 0, 0);
        c_ctl = 0; last = 0; nt = 0;
        for (int k = 0; k < 200 && nt < 5; k++) begin
            step();
            if (is_wr(3'd1)) c_ctl = cyc;
            if (tick) begin
                nt++;
                chk($sformatf("tick%0d_gap", nt), cyc - (nt == 1 ? c_ctl : last), nt == 1 ? 23 : 21);
                chk($sformatf("tick%0d_count", nt), 32'(tick_count), nt % 4);
                if (nt == 1) chk("ack_write", {11'h0, m_addr, m_cs, m_wn, m_wd}, {11'h0, 3'd0, 1'b1, 1'b0, 16'h0});
                last = cyc;
            end
        end
        chk("cont_ticks_seen", nt, 5);
        pulse(0, 1, 0);
        repeat (8) step();
        chk("cont_stopped", {30'h0, running, busy}, 0);

        // One-shot period 9: one tick only, count cleared on start
        cfg_period = 32'd9; cfg_cont = 1'b0;
        pulse(1, 0, 0);
        chk("oneshot_count_clear", 32'(tick_count), 0);
        ctl_wd = '0; acks = 0; nt = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (is_wr(3'd1)) ctl_wd = m_wd;
            if (is_wr(3'd0)) acks++;
            if (tick) nt++;
        end
        chk("oneshot_ctl", ctl_wd, 16'h0005);
        chk("oneshot_acks", acks, 1);
        chk("oneshot_ticks", nt, 1);
        chk("oneshot_state", {29'h0, running, busy, 32'(tick_count) == 1}, 1);

        // Snapshot in RUN, period 1000
        cfg_period = 32'd1000; cfg_cont = 1'b1;
        pulse(1, 0, 0);
        c_ctl = -1;
        for (int k = 0; k < 10 && c_ctl < 0; k++) begin
            step();
            if (is_wr(3'd1)) c_ctl = cyc;
        end
        chk("snap_ctl_seen", c_ctl >= 0, 1);
        repeat (50) step();
        pulse(0, 0, 1);
        w = -1; vc = -1;
        for (int k = 0; k < 20 && vc < 0; k++) begin
            if (is_wr(3'd4)) w = cyc;
            if (snap_valid) vc = cyc;
            if (vc < 0) step();
        end
        chk("snap_latency", vc - w, 4);
        chk("snap_value", snap_data, 32'(1000 - (w - c_ctl - 1)));
        chk("snap_range", snap_data <= 32'd1000, 1);
        pulse(0, 1, 0);
        repeat (8) step();

        // Timeout arriving mid-snapshot is serviced after it; a stop beats a later timeout
        cfg_period = 32'd20; cfg_cont = 1'b1;
        pulse(1, 0, 0);
        c_ctl = -1;
        for (int k = 0; k < 10 && c_ctl < 0; k++) begin
            step();
            if (is_wr(3'd1)) c_ctl = cyc;
        end
        chk("irqsnap_ctl_seen", c_ctl >= 0, 1);
        while (cyc < c_ctl + 20) step();
        pulse(0, 0, 1);
        vc = -1; tc = -1;
        for (int k = 0; k < 20; k++) begin
            if (snap_valid && vc < 0) vc = cyc;
            if (tick && tc < 0) tc = cyc;
            step();
        end
        chk("irqsnap_valid_cyc", vc - c_ctl, 25);
        chk("irqsnap_tick_cyc", tc - c_ctl, 26);
        chk("irqsnap_value", snap_data, 0);
        chk("irqsnap_count", 32'(tick_count), 1);
        while (cyc < c_ctl + 41) step();
        pulse(0, 1, 0);
        nt = 0;
        for (int k = 0; k < 30; k++) begin
            if (tick) nt++;
            step();
        end
        chk("stop_first_no_tick", nt, 0);
        chk("stop_first_idle", {30'h0, running, busy}, 0);

        // Reset mid-sequence aborts immediately
        pulse(1, 0, 0);
        step();
        reset_n = 1'b0;
        #1;
        chk("midreset_bus", {11'h0, m_addr, m_cs, m_wn, m_wd}, {11'h0, 3'd0, 1'b0, 1'b1, 16'h0});
        chk("midreset_status", {29'h0, busy, running, 32'(tick_count) != 0}, 0);
        step();
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
